// File: rtl/pcie_phy_pkg.sv
// Shared PHY constants and the striper state encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pcie_phy_pkg;

    localparam logic [7:0] K28_5_COM    = 8'hBC;
    localparam logic [7:0] K28_0_SKP    = 8'h1C;
    localparam logic [7:0] LOGICAL_IDLE = 8'h00;
    localparam int         SKP_OS_LEN   = 4;

    typedef enum logic [1:0] {
        LINK_DOWN,
        IDLE,
        DATA,
        SKP
    } striper_state_e;

endpackage

// File: rtl/pcie_skp_scheduler.sv
// Raises a sticky SKP request every SKP_INTERVAL enabled cycles.
// Latency: pending_o rises the cycle after the counter wraps.
// Backpressure: none; a second expiry while pending is absorbed.
module pcie_skp_scheduler #(
    parameter int SKP_INTERVAL = 1180
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic enable_i,
    input  logic consume_i,
    output logic pending_o
);

    localparam int              CW   = $clog2(SKP_INTERVAL);
    localparam logic [CW-1:0]   LAST = CW'(SKP_INTERVAL - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pending_q, pending_d;
    logic          expire;

    // Count while enabled; dropping enable (link down) clears both counter and request.
    always_comb begin
        cnt_d     = cnt_q;
        pending_d = pending_q;
        expire    = enable_i && (cnt_q == LAST);
        if (!enable_i) begin
            cnt_d     = '0;
            pending_d = 1'b0;
        end else begin
            cnt_d     = expire ? '0 : cnt_q + 1'b1;
            // A fresh expiry on the consume cycle starts a new request.
            pending_d = (pending_q && !consume_i) || expire;
        end
    end

    // Counter and request registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/pcie_tx_lane_striper.sv
// Byte-stripes MAC frames over 1..NUM_LANES lanes, filling gaps with idle and SKP ordered sets.
// Latency: chunk 0 of an accepted frame is on the lanes the next cycle; later chunks follow back to back.
// Backpressure: ready drops while chunks remain, an SKP is pending, or an SKP set is mid-flight.
module pcie_tx_lane_striper
    import pcie_phy_pkg::*;
#(
    parameter int MAC_FRAME_WIDTH = 32,
    parameter int NUM_LANES       = 4,
    parameter int SKP_INTERVAL    = 1180
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             link_up_i,
    input  logic [$clog2(NUM_LANES):0]       link_width_i,
    input  logic [MAC_FRAME_WIDTH-1:0]       mac_data_frame_i,
    input  logic                             mac_data_frame_valid_i,
    output logic                             mac_data_frame_ready_o,
    output logic [NUM_LANES*8-1:0]           lane_data_o,
    output logic [NUM_LANES-1:0]             lane_k_o,
    output logic [NUM_LANES-1:0]             lane_active_o,
    output logic                             lane_valid_o,
    output logic                             skp_active_o
);

    localparam int BYTES = MAC_FRAME_WIDTH / 8;
    localparam int LOG2L = $clog2(NUM_LANES);
    localparam int LWW   = LOG2L + 1;
    localparam int RW    = $clog2(BYTES) + 1;
    localparam logic [1:0] SKP_LAST = 2'(SKP_OS_LEN - 1);

    striper_state_e               state_q, state_d;
    logic [1:0]                   skp_idx_q, skp_idx_d;
    logic [RW-1:0]                remain_q, remain_d;
    logic [MAC_FRAME_WIDTH-1:0]   hold_q, hold_d;
    logic [LWW-1:0]               wlog_q, wlog_d;
    logic [NUM_LANES*8-1:0]       lane_data_q, lane_data_d;
    logic [NUM_LANES-1:0]         lane_k_q, lane_k_d;
    logic [NUM_LANES-1:0]         lane_active_q, lane_active_d;
    logic                         lane_valid_q, lane_valid_d;
    logic                         skp_active_q, skp_active_d;

    logic                         skp_pending;
    logic                         skp_consume;
    logic                         accept;
    logic [LWW-1:0]               w_in;

    // Lowest 2^lw lanes set.
    function automatic logic [NUM_LANES-1:0] lane_mask(input logic [LWW-1:0] lw);
        for (int n = 0; n < NUM_LANES; n++) begin
            lane_mask[n] = ((n >> lw) == 0);
        end
    endfunction

    // Low bytes of src onto the active lanes, idle elsewhere.
    function automatic logic [NUM_LANES*8-1:0] stripe(input logic [MAC_FRAME_WIDTH-1:0] src,
                                                      input logic [NUM_LANES-1:0]       m);
        for (int n = 0; n < NUM_LANES; n++) begin
            stripe[8*n +: 8] = m[n] ? src[8*n +: 8] : LOGICAL_IDLE;
        end
    endfunction

    // Same symbol on every active lane.
    function automatic logic [NUM_LANES*8-1:0] fill(input logic [7:0] sym,
                                                    input logic [NUM_LANES-1:0] m);
        for (int n = 0; n < NUM_LANES; n++) begin
            fill[8*n +: 8] = m[n] ? sym : LOGICAL_IDLE;
        end
    endfunction

    // Clamp requested width to what the PHY has.
    assign w_in = (link_width_i > LWW'(LOG2L)) ? LWW'(LOG2L) : link_width_i;

    assign mac_data_frame_ready_o = link_up_i && (state_q != LINK_DOWN) && !skp_pending &&
                                    !((state_q == SKP) && (skp_idx_q != SKP_LAST)) &&
                                    (remain_q == '0);
    assign accept = mac_data_frame_valid_i && mac_data_frame_ready_o;

    pcie_skp_scheduler #(
        .SKP_INTERVAL (SKP_INTERVAL)
    ) u_skp_sched (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .enable_i  (link_up_i && (state_q != LINK_DOWN)),
        .consume_i (skp_consume),
        .pending_o (skp_pending)
    );

    // Next state and next registered lane outputs; priority: link, SKP in flight, frame tail, new frame, SKP, idle.
    always_comb begin
        state_d       = state_q;
        skp_idx_d     = skp_idx_q;
        remain_d      = remain_q;
        hold_d        = hold_q;
        wlog_d        = wlog_q;
        lane_data_d   = '0;
        lane_k_d      = '0;
        lane_active_d = lane_mask(wlog_q);
        lane_valid_d  = 1'b1;
        skp_active_d  = 1'b0;
        skp_consume   = 1'b0;
        if (!link_up_i) begin
            // Discard everything; width falls back to x1 until the next frame is accepted.
            state_d       = LINK_DOWN;
            skp_idx_d     = '0;
            remain_d      = '0;
            hold_d        = '0;
            wlog_d        = '0;
            lane_active_d = '0;
            lane_valid_d  = 1'b0;
        end else if (state_q == LINK_DOWN) begin
            state_d = IDLE;
        end else if ((state_q == SKP) && (skp_idx_q != SKP_LAST)) begin
            skp_idx_d    = skp_idx_q + 1'b1;
            lane_data_d  = fill(K28_0_SKP, lane_mask(wlog_q));
            lane_k_d     = lane_mask(wlog_q);
            skp_active_d = 1'b1;
        end else if (remain_q != '0) begin
            state_d     = DATA;
            lane_data_d = stripe(hold_q, lane_mask(wlog_q));
            hold_d      = hold_q >> (8 << wlog_q);
            remain_d    = remain_q - 1'b1;
        end else if (accept) begin
            state_d       = DATA;
            wlog_d        = w_in;
            lane_active_d = lane_mask(w_in);
            lane_data_d   = stripe(mac_data_frame_i, lane_mask(w_in));
            hold_d        = mac_data_frame_i >> (8 << w_in);
            remain_d      = RW'((BYTES >> w_in) - 1);
        end else if (skp_pending) begin
            state_d      = SKP;
            skp_idx_d    = '0;
            skp_consume  = 1'b1;
            lane_data_d  = fill(K28_5_COM, lane_mask(wlog_q));
            lane_k_d     = lane_mask(wlog_q);
            skp_active_d = 1'b1;
        end else begin
            state_d = IDLE;
        end
    end

    // State, frame holding and output registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= LINK_DOWN;
            skp_idx_q     <= '0;
            remain_q      <= '0;
            hold_q        <= '0;
            wlog_q        <= '0;
            lane_data_q   <= '0;
            lane_k_q      <= '0;
            lane_active_q <= '0;
            lane_valid_q  <= 1'b0;
            skp_active_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            skp_idx_q     <= skp_idx_d;
            remain_q      <= remain_d;
            hold_q        <= hold_d;
            wlog_q        <= wlog_d;
            lane_data_q   <= lane_data_d;
            lane_k_q      <= lane_k_d;
            lane_active_q <= lane_active_d;
            lane_valid_q  <= lane_valid_d;
            skp_active_q  <= skp_active_d;
        end
    end

    assign lane_data_o   = lane_data_q;
    assign lane_k_o      = lane_k_q;
    assign lane_active_o = lane_active_q;
    assign lane_valid_o  = lane_valid_q;
    assign skp_active_o  = skp_active_q;

endmodule

// File: tb/tb_pcie_tx_lane_striper.sv
// Directed bench for the lane striper: vector table for striping, hand sequences for SKP and link events.
// Latency: inputs driven and outputs sampled 1ns after each rising edge.
// Backpressure: ready is checked combinationally before each edge.
module tb_pcie_tx_lane_striper;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        link_up_i;
    logic [2:0]  link_width_i;
    logic [31:0] mac_data_frame_i;
    logic        mac_data_frame_valid_i;
    logic        mac_data_frame_ready_o;
    logic [31:0] lane_data_o;
    logic [3:0]  lane_k_o;
    logic [3:0]  lane_active_o;
    logic        lane_valid_o;
    logic        skp_active_o;

    int total = 0;
    int bad   = 0;

    pcie_tx_lane_striper #(
        .MAC_FRAME_WIDTH (32),
        .NUM_LANES       (4),
        .SKP_INTERVAL    (16)
    ) dut (
        .clk_i                  (clk_i),
        .rst_i                  (rst_i),
        .link_up_i              (link_up_i),
        .link_width_i           (link_width_i),
        .mac_data_frame_i       (mac_data_frame_i),
        .mac_data_frame_valid_i (mac_data_frame_valid_i),
        .mac_data_frame_ready_o (mac_data_frame_ready_o),
        .lane_data_o            (lane_data_o),
        .lane_k_o               (lane_k_o),
        .lane_active_o          (lane_active_o),
        .lane_valid_o           (lane_valid_o),
        .skp_active_o           (skp_active_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        link;
        logic [2:0]  w;
        logic        vld;
        logic [31:0] dat;
        logic        rdy;
        logic [31:0] lanes;
        logic [3:0]  k;
        logic [3:0]  act;
        logic        lvld;
        logic        skp;
    } vec_t;

    vec_t tbl [20];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic relink();
        link_up_i = 1'b0;
        mac_data_frame_valid_i = 1'b0;
        tick();
        link_up_i = 1'b1;
        tick();
    endtask

    // Called right after the link-up edge; expects COM 17 edges later, then three SKPs.
    task automatic wait_com(input string tag);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        while (!seen && n < 40) begin
            tick();
            n++;
            if (n == 16) chk({tag, "_rdy_pending"}, 32'(mac_data_frame_ready_o), 32'd0);
            if (lane_data_o[7:0] == 8'hBC && lane_k_o[0]) begin
                seen = 1;
            end else begin
                chk({tag, "_idle_lane0"}, {23'd0, lane_k_o[0], lane_data_o[7:0]}, 32'd0);
                chk({tag, "_idle_skp"}, 32'(skp_active_o), 32'd0);
            end
        end
        chk({tag, "_com_cycle"}, n, 17);
        chk({tag, "_com_skp"}, 32'(skp_active_o), 32'd1);
        chk({tag, "_com_rdy"}, 32'(mac_data_frame_ready_o), 32'd0);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk($sformatf("%s_skp%0d_lane0", tag, i), {23'd0, lane_k_o[0], lane_data_o[7:0]}, 32'h11C);
            chk($sformatf("%s_skp%0d_act", tag, i), 32'(skp_active_o), 32'd1);
            chk($sformatf("%s_skp%0d_rdy", tag, i), 32'(mac_data_frame_ready_o), (i == 3) ? 32'd1 : 32'd0);
        end
        tick();
        chk({tag, "_after_skp"}, {23'd0, lane_k_o[0], lane_data_o[7:0]}, 32'd0);
        chk({tag, "_after_skp_act"}, 32'(skp_active_o), 32'd0);
    endtask

    logic [7:0] exp_b [9];
    logic       exp_k [9];
    logic       exp_r [9];

    initial begin
        //               link w     vld  dat            rdy   lanes          k     act      lvld  skp
        tbl[0]  = '{1'b0, 3'd2, 1'b0, 32'h0,        1'b0, 32'h0,        4'h0, 4'b0000, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 3'd2, 1'b0, 32'h0,        1'b0, 32'h0,        4'h0, 4'b0001, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 3'd2, 1'b1, 32'h44332211, 1'b1, 32'h44332211, 4'h0, 4'b1111, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 3'd2, 1'b1, 32'h88776655, 1'b1, 32'h88776655, 4'h0, 4'b1111, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 3'd2, 1'b0, 32'h0,        1'b1, 32'h0,        4'h0, 4'b1111, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 3'd1, 1'b0, 32'h0,        1'b0, 32'h0,        4'h0, 4'b0000, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 3'd1, 1'b0, 32'h0,        1'b0, 32'h0,        4'h0, 4'b0001, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 3'd1, 1'b1, 32'h44332211, 1'b1, 32'h00002211, 4'h0, 4'b0011, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 3'd1, 1'b1, 32'hDEADBEEF, 1'b0, 32'h00004433, 4'h0, 4'b0011, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 3'd1, 1'b1, 32'hDEADBEEF, 1'b1, 32'h0000BEEF, 4'h0, 4'b0011, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 3'd1, 1'b0, 32'h0,        1'b0, 32'h0000DEAD, 4'h0, 4'b0011, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 3'd1, 1'b0, 32'h0,        1'b1, 32'h0,        4'h0, 4'b0011, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 3'd0, 1'b0, 32'h0,        1'b0, 32'h0,        4'h0, 4'b0000, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 3'd0, 1'b0, 32'h0,        1'b0, 32'h0,        4'h0, 4'b0001, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 3'd0, 1'b1, 32'hDDCCBBAA, 1'b1, 32'h000000AA, 4'h0, 4'b0001, 1'b1, 1'b0};
        tbl[15] = '{1'b1, 3'd3, 1'b1, 32'h11111111, 1'b0, 32'h000000BB, 4'h0, 4'b0001, 1'b1, 1'b0};
        tbl[16] = '{1'b1, 3'd3, 1'b1, 32'h11111111, 1'b0, 32'h000000CC, 4'h0, 4'b0001, 1'b1, 1'b0};
        tbl[17] = '{1'b1, 3'd3, 1'b1, 32'h11111111, 1'b0, 32'h000000DD, 4'h0, 4'b0001, 1'b1, 1'b0};
        tbl[18] = '{1'b1, 3'd3, 1'b1, 32'h44332211, 1'b1, 32'h44332211, 4'h0, 4'b1111, 1'b1, 1'b0};
        tbl[19] = '{1'b1, 3'd3, 1'b0, 32'h0,        1'b1, 32'h0,        4'h0, 4'b1111, 1'b1, 1'b0};

        exp_b = '{8'hBB, 8'hCC, 8'hDD, 8'hBC, 8'h1C, 8'h1C, 8'h1C, 8'h11, 8'h22};
        exp_k = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_r = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset state
        rst_i = 1'b0;
        link_up_i = 1'b0;
        link_width_i = 3'd2;
        mac_data_frame_i = 32'h0;
        mac_data_frame_valid_i = 1'b0;
        #3;
        chk("rst_lanes", lane_data_o, 32'h0);
        chk("rst_misc", {20'd0, lane_k_o, lane_active_o, 2'b00, lane_valid_o, skp_active_o}, 32'h0);
        chk("rst_rdy", 32'(mac_data_frame_ready_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        tick();

        // Striping table: x4 stream, x2 stripe, x1 and clamp
        for (int i = 0; i < 20; i++) begin
            link_up_i = tbl[i].link;
            link_width_i = tbl[i].w;
            mac_data_frame_valid_i = tbl[i].vld;
            mac_data_frame_i = tbl[i].dat;
            #1;
            chk($sformatf("row%0d_rdy", i), 32'(mac_data_frame_ready_o), 32'(tbl[i].rdy));
            tick();
            chk($sformatf("row%0d_lanes", i), lane_data_o, tbl[i].lanes);
            chk($sformatf("row%0d_k", i), 32'(lane_k_o), 32'(tbl[i].k));
            chk($sformatf("row%0d_act", i), 32'(lane_active_o), 32'(tbl[i].act));
            chk($sformatf("row%0d_lvld", i), 32'(lane_valid_o), 32'(tbl[i].lvld));
            chk($sformatf("row%0d_skp", i), 32'(skp_active_o), 32'(tbl[i].skp));
        end

        // SKP from idle
        relink();
        wait_com("idle_skp");

        // SKP deferred behind an x1 frame: expiry lands on chunk 1
        relink();
        for (int i = 0; i < 14; i++) tick();
        link_width_i = 3'd0;
        mac_data_frame_i = 32'hDDCCBBAA;
        mac_data_frame_valid_i = 1'b1;
        #1;
        chk("defer_rdy0", 32'(mac_data_frame_ready_o), 32'd1);
        tick();
        chk("defer_chunk0", {23'd0, lane_k_o[0], lane_data_o[7:0]}, 32'h0AA);
        mac_data_frame_i = 32'h44332211;
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("defer_rdy%0d", i + 1), 32'(mac_data_frame_ready_o), 32'(exp_r[i]));
            tick();
            chk($sformatf("defer_lane0_%0d", i + 1), {23'd0, lane_k_o[0], lane_data_o[7:0]},
                {23'd0, exp_k[i], exp_b[i]});
        end
        mac_data_frame_valid_i = 1'b0;

        // Link drop mid-frame, then relink restarts the SKP counter
        relink();
        link_width_i = 3'd0;
        mac_data_frame_i = 32'hDDCCBBAA;
        mac_data_frame_valid_i = 1'b1;
        tick();
        mac_data_frame_valid_i = 1'b0;
        tick();
        chk("drop_chunk1", {24'd0, lane_data_o[7:0]}, 32'h0BB);
        link_up_i = 1'b0;
        #1;
        chk("drop_rdy", 32'(mac_data_frame_ready_o), 32'd0);
        tick();
        chk("drop_lanes", lane_data_o, 32'h0);
        chk("drop_misc", {20'd0, lane_k_o, lane_active_o, 2'b00, lane_valid_o, skp_active_o}, 32'h0);
        link_up_i = 1'b1;
        tick();
        chk("relink_lvld", 32'(lane_valid_o), 32'd1);
        chk("relink_lanes", lane_data_o, 32'h0);
        wait_com("relink_skp");

        // Asynchronous reset mid-frame
        relink();
        link_width_i = 3'd0;
        mac_data_frame_i = 32'hDDCCBBAA;
        mac_data_frame_valid_i = 1'b1;
        tick();
        mac_data_frame_valid_i = 1'b0;
        chk("arst_pre", {24'd0, lane_data_o[7:0]}, 32'h0AA);
        #2;
        rst_i = 1'b0;
        #1;
        chk("arst_lanes", lane_data_o, 32'h0);
        chk("arst_misc", {20'd0, lane_k_o, lane_active_o, 2'b00, lane_valid_o, skp_active_o}, 32'h0);
        chk("arst_rdy", 32'(mac_data_frame_ready_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        tick();
        chk("arst_relink_lvld", 32'(lane_valid_o), 32'd1);
        tick();
        chk("arst_idle_lanes", lane_data_o, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
